// File: rtl/lsu_pkg.sv
// Shared encodings and defaults for the load/store unit.
package lsu_pkg;

    localparam int LSU_MEM_WORDS = 16;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle and memory-side strobe bundle.
interface lsu_req_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        respValid;
    logic [31:0] respData;
    logic        respErr;

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData,
        input  reqReady, respValid, respData, respErr
    );
    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData,
        output reqReady, respValid, respData, respErr
    );
endinterface

interface lsu_mem_if;
    logic [31:0] memAddress;
    logic [31:0] memDataIn;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memDataOut;

    modport master (
        output memAddress, memDataIn, memRead, memWrite,
        input  memDataOut
    );
    modport slave (
        input  memAddress, memDataIn, memRead, memWrite,
        output memDataOut
    );
endinterface

// File: rtl/lsu_lane_unit.sv
// Little-endian lane extract (loads) and lane merge (stores); LSU_SUBWORD_EN builds sub-word lanes.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);
`ifdef LSU_SUBWORD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {lane, 3'b000});
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        ld_data = rdata;
        st_data = wdata;
        case (size)
            SIZE_BYTE: begin
                ld_data = {{24{sgn & byte_sel[7]}}, byte_sel};
                st_data = rdata;
                st_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                ld_data = {{16{sgn & half_sel[15]}}, half_sel};
                st_data = rdata;
                st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end
`else
    logic unused_lane;

    assign unused_lane = ^{lane, size, sgn};
    assign ld_data     = rdata;
    assign st_data     = wdata;
`endif
endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed data memory; LSU_SUBWORD_EN enables byte/halfword.
// Latency: error 1, load/word store 2, sub-word store (read-modify-write) 3 cycles to respValid.
// Backpressure: reqReady high only in IDLE; one request in flight at a time.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic      clk,
    input  logic      rstN,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    lsu_state_t  state_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        sgn_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] resp_data_q;
    logic        resp_vld_q;
    logic        resp_err_q;
    logic        req_err;
    logic [31:0] ld_data;
    logic [31:0] st_data;
`ifdef LSU_SUBWORD_EN
    logic        wr_q;
`else
    logic        unused_st;

    assign unused_st = ^st_data;
`endif

    always_comb begin
        req_err = ({2'b00, req.reqAddr[31:2]} >= 32'(MEM_WORDS));
`ifdef LSU_SUBWORD_EN
        if (req.reqSize == 2'b11)                                     req_err = 1'b1;
        if (req.reqSize == SIZE_HALF && req.reqAddr[0])               req_err = 1'b1;
        if (req.reqSize == SIZE_WORD && req.reqAddr[1:0] != 2'b00)    req_err = 1'b1;
`else
        if (req.reqSize != SIZE_WORD || req.reqAddr[1:0] != 2'b00)    req_err = 1'b1;
`endif
    end

    lsu_lane_unit u_lane (
        .lane    (lane_q),
        .size    (size_q),
        .sgn     (sgn_q),
        .rdata   (mem.memDataOut),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            size_q      <= '0;
            lane_q      <= '0;
            sgn_q       <= 1'b0;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            resp_data_q <= '0;
            resp_vld_q  <= 1'b0;
            resp_err_q  <= 1'b0;
`ifdef LSU_SUBWORD_EN
            wr_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req.reqValid) begin
                    size_q  <= req.reqSize;
                    lane_q  <= req.reqAddr[1:0];
                    sgn_q   <= req.reqSigned;
                    wdata_q <= req.reqData;
                    addr_q  <= {2'b00, req.reqAddr[31:2]};
`ifdef LSU_SUBWORD_EN
                    wr_q    <= req.reqWrite;
`endif
                    if (req_err) begin
                        resp_vld_q  <= 1'b1;
                        resp_err_q  <= 1'b1;
                        resp_data_q <= '0;
                        state_q     <= DONE;
                    end else if (!req.reqWrite) begin
                        state_q <= READ;
`ifdef LSU_SUBWORD_EN
                    end else if (req.reqSize != SIZE_WORD) begin
                        // sub-word store fetches the target word first
                        state_q <= READ;
`endif
                    end else begin
                        mem_wdata_q <= req.reqData;
                        state_q     <= WRITE;
                    end
                end
                READ: begin
`ifdef LSU_SUBWORD_EN
                    if (wr_q) begin
                        mem_wdata_q <= st_data;
                        state_q     <= WRITE;
                    end else begin
                        resp_vld_q  <= 1'b1;
                        resp_err_q  <= 1'b0;
                        resp_data_q <= ld_data;
                        state_q     <= DONE;
                    end
`else
                    resp_vld_q  <= 1'b1;
                    resp_err_q  <= 1'b0;
                    resp_data_q <= ld_data;
                    state_q     <= DONE;
`endif
                end
                WRITE: begin
                    resp_vld_q  <= 1'b1;
                    resp_err_q  <= 1'b0;
                    resp_data_q <= '0;
                    state_q     <= DONE;
                end
                default: begin
                    resp_vld_q  <= 1'b0;
                    resp_err_q  <= 1'b0;
                    resp_data_q <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req.reqReady  = (state_q == IDLE);
    assign req.respValid = resp_vld_q;
    assign req.respErr   = resp_err_q;
    assign req.respData  = resp_data_q;
    assign mem.memRead    = (state_q == READ);
    assign mem.memWrite   = (state_q == WRITE);
    assign mem.memAddress = addr_q;
    assign mem.memDataIn  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word behavioural data memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rstN;
    lsu_req_if ri ();
    lsu_mem_if mi ();

    load_store_unit #(.MEM_WORDS(16)) dut (
        .clk  (clk),
        .rstN (rstN),
        .req  (ri.slave),
        .mem  (mi.master)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_arr [0:15];
    assign mi.memDataOut = (mi.memAddress < 32'd16) ? mem_arr[mi.memAddress[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (mi.memWrite && mi.memAddress < 32'd16)
            mem_arr[mi.memAddress[3:0]] <= mi.memDataIn;
    end

    int cyc = 0, rd_tot = 0, wr_tot = 0, both_tot = 0, rd_cyc = 0, wr_cyc = 0;
    logic [31:0] wr_addr = '0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mi.memRead)  begin rd_tot <= rd_tot + 1; rd_cyc <= cyc; end
        if (mi.memWrite) begin wr_tot <= wr_tot + 1; wr_cyc <= cyc; wr_addr <= mi.memAddress; end
        if (mi.memRead && mi.memWrite) both_tot <= both_tot + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        ri.reqWrite  = wr;
        ri.reqSize   = sz;
        ri.reqSigned = sg;
        ri.reqAddr   = a;
        ri.reqData   = d;
        ri.reqValid  = 1'b1;
        @(posedge clk);
        #1;
        // scramble fields to expose any use of live inputs after acceptance
        ri.reqValid  = 1'b0;
        ri.reqAddr   = 32'hFFFF_FFFC;
        ri.reqData   = ~d;
        ri.reqSigned = ~sg;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ri.respValid) begin
                lat = c;
                rd  = ri.respData;
                er  = ri.respErr;
                break;
            end
        end
    endtask

    task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input int e_lat, input logic [31:0] e_data, input logic e_err,
                        input int e_rd, input int e_wr);
        int lat, r0, w0;
        logic [31:0] rd;
        logic er;
        r0 = rd_tot;
        w0 = wr_tot;
        do_req(wr, sz, sg, a, d, lat, rd, er);
        chk({tag, "_lat"},  32'(lat), 32'(e_lat));
        chk({tag, "_data"}, rd, e_data);
        chk({tag, "_err"},  {31'b0, er}, {31'b0, e_err});
        chk({tag, "_nrd"},  32'(rd_tot - r0), 32'(e_rd));
        chk({tag, "_nwr"},  32'(wr_tot - w0), 32'(e_wr));
    endtask

    initial begin
        int w0, v0;
        rstN         = 1'b0;
        ri.reqValid  = 1'b0;
        ri.reqWrite  = 1'b0;
        ri.reqSize   = 2'b00;
        ri.reqSigned = 1'b0;
        ri.reqAddr   = '0;
        ri.reqData   = '0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, ri.reqReady},  32'd1);
        chk("rst_rvld",  {31'b0, ri.respValid}, 32'd0);
        chk("rst_rerr",  {31'b0, ri.respErr},   32'd0);
        chk("rst_rdata", ri.respData,           32'd0);
        chk("rst_strb",  {30'b0, mi.memRead, mi.memWrite}, 32'd0);
        chk("rst_addr",  mi.memAddress,         32'd0);
        chk("rst_wdat",  mi.memDataIn,          32'd0);

        xact("sw8", 1'b1, SIZE_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
        chk("sw8_addr", wr_addr, 32'd2);
        chk("sw8_mem",  mem_arr[2], 32'hDEADBEEF);
        xact("lw8",  1'b0, SIZE_WORD, 1'b0, 32'h8,  32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);
        xact("lw6",  1'b0, SIZE_WORD, 1'b0, 32'h6,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("lh3",  1'b0, SIZE_HALF, 1'b0, 32'h3,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("sz11", 1'b0, 2'b11,     1'b0, 32'h0,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("lw40", 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("sw40", 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h12345678, 1, 32'h0, 1'b1, 0, 0);

`ifdef LSU_SUBWORD_EN
        xact("swC",  1'b1, SIZE_WORD, 1'b0, 32'hC, 32'h000080F0, 2, 32'h0, 1'b0, 0, 1);
        xact("lbC",  1'b0, SIZE_BYTE, 1'b1, 32'hC, 32'h0, 2, 32'hFFFFFFF0, 1'b0, 1, 0);
        xact("lhuC", 1'b0, SIZE_HALF, 1'b0, 32'hC, 32'h0, 2, 32'h000080F0, 1'b0, 1, 0);
        xact("lhE",  1'b1 ^ 1'b1, SIZE_HALF, 1'b1, 32'hE, 32'h0, 2, 32'h00000000, 1'b0, 1, 0);
        xact("lbuD", 1'b0, SIZE_BYTE, 1'b0, 32'hD, 32'h0, 2, 32'h00000080, 1'b0, 1, 0);
        xact("lbD",  1'b0, SIZE_BYTE, 1'b1, 32'hD, 32'h0, 2, 32'hFFFFFF80, 1'b0, 1, 0);
        xact("sw4",  1'b1, SIZE_WORD, 1'b0, 32'h4, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
        xact("sb5",  1'b1, SIZE_BYTE, 1'b0, 32'h5, 32'hFFFFFFAA, 3, 32'h0, 1'b0, 1, 1);
        chk("sb5_order", 32'(wr_cyc - rd_cyc), 32'd1);
        chk("sb5_mem",   mem_arr[1], 32'h1122AA44);
        xact("sh6",  1'b1, SIZE_HALF, 1'b0, 32'h6, 32'h12345678, 3, 32'h0, 1'b0, 1, 1);
        chk("sh6_mem",   mem_arr[1], 32'h5678AA44);
`else
        xact("lb0",  1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("sb5",  1'b1, SIZE_BYTE, 1'b0, 32'h5, 32'hAA, 1, 32'h0, 1'b1, 0, 0);
        xact("lh0",  1'b0, SIZE_HALF, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
`endif

        // abort a request while it sits in READ
        w0 = wr_tot;
        @(negedge clk);
`ifdef LSU_SUBWORD_EN
        ri.reqWrite = 1'b1;
        ri.reqSize  = SIZE_BYTE;
        ri.reqAddr  = 32'h4;
        ri.reqData  = 32'h99;
`else
        ri.reqWrite = 1'b0;
        ri.reqSize  = SIZE_WORD;
        ri.reqAddr  = 32'h8;
        ri.reqData  = 32'h0;
`endif
        ri.reqValid = 1'b1;
        @(posedge clk);
        #1;
        ri.reqValid = 1'b0;
        #1;
        chk("abort_in_read", {31'b0, mi.memRead}, 32'd1);
        rstN = 1'b0;
        #1;
        chk("abort_strb",  {30'b0, mi.memRead, mi.memWrite}, 32'd0);
        chk("abort_ready", {31'b0, ri.reqReady}, 32'd1);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        v0 = 0;
        repeat (6) begin
            @(negedge clk);
            if (ri.respValid) v0++;
        end
        chk("abort_noresp", 32'(v0), 32'd0);
        chk("abort_nowr",   32'(wr_tot - w0), 32'd0);
        chk("abort_ready2", {31'b0, ri.reqReady}, 32'd1);
`ifdef LSU_SUBWORD_EN
        chk("abort_mem", mem_arr[1], 32'h5678AA44);
`else
        chk("abort_mem", mem_arr[2], 32'hDEADBEEF);
`endif

        xact("lw8b", 1'b0, SIZE_WORD, 1'b0, 32'h8, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);
        chk("never_both", 32'(both_tot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
